output_model: RTL
=================

// Module: output_model
// PURPOSE
//  Capture-side counterpart of the stimulus model: samples the DUT result stream
//  (valid + data) every clk into a circular capture buffer.
//  A downstream reader (scoreboard/checker) drains it through a valid/ready port.
//  Tracks accepted, dropped and total-seen counts.
//  Sits between DUT result outputs and the checker in generated_tb.
// PARAMETERS
//  DATA_W   8    width of captured result word
//  DEPTH    16   capture buffer entries; power of two, >=2
//  CNT_W    16   width of accepted/dropped counters (saturating)
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            synchronous reset, active-low
//  cap_en       in   1            1 = capture enabled; 0 = ignore in_valid
//  clear        in   1            synchronous flush of buffer, counters and flags
//  in_valid     in   1            DUT result valid this cycle
//  in_data      in   DATA_W       DUT result word
//  rd_ready     in   1            reader accepts rd_data this cycle
//  rd_valid     out  1            buffer non-empty; rd_data valid
//  rd_data      out  DATA_W       oldest captured word (first-word-fall-through)
//  level        out  $clog2(DEPTH)+1  entries currently held
//  full         out  1            level == DEPTH
//  overflow     out  1            sticky: a capture was dropped because buffer full
//  accepted_cnt out  CNT_W        words written into buffer
//  dropped_cnt  out  CNT_W        words lost to full buffer
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//   - wr_ptr=rd_ptr=0, level=0, overflow=0, counters=0.
//   - rd_valid=0, full=0; rd_data=0 (memory contents don't care).
//  clear=1: same effect as reset; takes priority over capture/read that cycle.
//   - rst_n has priority over clear.
//  Capture (write) condition: cap_en & in_valid.
//   - level<DEPTH, or read fires same cycle: mem[wr_ptr]<=in_data, wr_ptr++,
//     accepted_cnt++.
//   - Full and no read: word dropped, overflow<=1, dropped_cnt++.
//  Read fires when rd_valid & rd_ready: rd_ptr++.
//   - rd_ready while empty is ignored.
//  rd_valid = (level!=0); rd_data = mem[rd_ptr], combinational from registered state.
//  Latency: word captured at edge N appears on rd_data after edge N (1 cycle).
//   - No same-cycle bypass when empty.
//  Simultaneous write+read: level unchanged.
//   - Full+read+write: both accepted, no drop.
//  Pointers: $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally.
//   - level tracked as separate counter.
//  Counters saturate at 2**CNT_W-1 (no wrap); overflow stays 1 until reset/clear.
//  Ordering: strict FIFO; no reordering, no duplication.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with in_valid=1 -> level=0, rd_valid=0,
//    counters=0, overflow=0.
//  2 Basic: cap_en=1, push 0x11,0x22,0x33 on 3 cycles, rd_ready=0
//    -> level=3, rd_data=0x11.
//    - Then rd_ready=1 -> 0x11,0x22,0x33 on successive cycles, rd_valid=0 after.
//  3 Overflow (DEPTH=16): push 0x00..0x13 (20 words), no reads
//    -> full=1, accepted_cnt=16, dropped_cnt=4, overflow=1.
//    - Drain yields 0x00..0x0F in order.
//  4 Full + simultaneous: buffer full, in_valid=1 data 0xAA with rd_ready=1
//    -> no drop, level stays 16, 0xAA last read out.
//  5 Wrap + streaming: 40 words with rd_ready=1 every cycle
//    -> level<=1, all 40 read in order, dropped_cnt=0.
//  6 Clear/cap_en: clear mid-stream with level=5 -> next cycle level=0, counters=0.
//    - cap_en=0 with in_valid=1 -> nothing stored.

Source files
------------

// File: rtl/output_model.sv
// output_model
//   Capture-side buffer for a result stream. Every clk where cap_en & in_valid
//   is high, in_data is captured into a circular buffer of DEPTH entries. A
//   downstream reader drains the buffer through a first-word-fall-through
//   valid/ready port. Captures that meet a full buffer (with no read in the
//   same cycle) are dropped and recorded in a sticky overflow flag and a
//   saturating drop counter.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   cap_en       capture enable; 0 ignores in_valid
//   clear        synchronous flush of buffer, counters and flags
//   in_valid     result word valid this cycle
//   in_data      result word
//   rd_ready     reader accepts rd_data this cycle
//   rd_valid     buffer non-empty, rd_data valid
//   rd_data      oldest captured word (0 while empty)
//   level        entries currently held
//   full         level == DEPTH
//   overflow     sticky: a capture was dropped because the buffer was full
//   accepted_cnt words written into the buffer (saturating)
//   dropped_cnt  words lost to a full buffer (saturating)
module output_model #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cap_en,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         accepted_cnt,
    output logic [CNT_W-1:0]         dropped_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    logic wr_req;
    logic rd_fire;
    logic wr_fire;
    logic drop;
    logic flush;

    assign flush    = !rst_n || clear;
    assign rd_valid = (level != '0);
    assign full     = (level == LW'(DEPTH));
    assign rd_fire  = rd_valid && rd_ready;
    assign wr_req   = cap_en && in_valid;
    // A full buffer still accepts a write when a read frees a slot this cycle.
    assign wr_fire  = wr_req && (!full || rd_fire);
    assign drop     = wr_req && full && !rd_fire;

    // Gated to zero when empty so reset/clear present a defined rd_data
    // without needing to reset the storage array.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // ---- storage write stage (data path, no reset) ----
    always_ff @(posedge clk) begin
        if (wr_fire && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // ---- control state: pointers, level, flags, counters ----
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            accepted_cnt <= '0;
            dropped_cnt  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr       <= wr_ptr + 1'b1;
                accepted_cnt <= sat_inc(accepted_cnt);
            end
            if (drop) begin
                overflow    <= 1'b1;
                dropped_cnt <= sat_inc(dropped_cnt);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_fire && !rd_fire) begin
                level <= level + 1'b1;
            end else if (!wr_fire && rd_fire) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule
